iq_sync_fifo: RTL
=================

// Module: iq_sync_fifo
// PURPOSE
//  Single-clock I/Q sample FIFO for paths where producer and consumer share one clock.
//  Examples: modem-side rate buffering and SPI/debug sample capture.
//  Stores {I,Q} pairs in block RAM. Adds these over the dual-clock FIFO:
//  fill level, programmable almost-full/almost-empty, sticky overflow/underflow,
//  saturating drop counter, synchronous flush, debug-word inject/readback.
// PARAMETERS
//  ADDR_WIDTH   9              log2 depth; DEPTH = 2**ADDR_WIDTH entries
//  DATA_WIDTH   16             width of each I and Q component
//  DEBUG_WORD   32'hABCDEF01   constant used by debug push/pull (2*DATA_WIDTH bits)
//  CNT_WIDTH    16             width of drop counter
// PORTS
//  clk_i            in   1              single clock, rising edge
//  rst_b_i          in   1              asynchronous active-low reset
//  flush_i          in   1              synchronous flush: empty FIFO, keep flags/counter
//  wr_en_i          in   1              write request
//  wr_data_i        in   2*DATA_WIDTH   {I[31:16], Q[15:0]} for DATA_WIDTH=16
//  rd_en_i          in   1              read request
//  rd_data_o        out  2*DATA_WIDTH   registered read data, same packing
//  rd_valid_o       out  1              rd_data_o holds a newly popped word
//  full_o           out  1              level == DEPTH
//  empty_o          out  1              level == 0
//  almost_full_o    out  1              level >= af_thresh_i
//  almost_empty_o   out  1              level <= ae_thresh_i
//  af_thresh_i      in   ADDR_WIDTH+1   almost-full threshold, static
//  ae_thresh_i      in   ADDR_WIDTH+1   almost-empty threshold, static
//  level_o          out  ADDR_WIDTH+1   current occupancy 0..DEPTH
//  overflow_o       out  1              sticky: a write was dropped
//  underflow_o      out  1              sticky: a read was refused
//  drop_cnt_o       out  CNT_WIDTH      saturating count of dropped writes
//  clr_flags_i      in   1              clears overflow_o, underflow_o, drop_cnt_o
//  debug_push_i     in   1              accepted write stores DEBUG_WORD
//  debug_pull_i     in   1              accepted read returns DEBUG_WORD; still pops
// BEHAVIOUR
//  Reset (async, rst_b_i=0):
//   - Pointers, level, rd_data_o, rd_valid_o, flags and counter go to 0.
//   - empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
//   - Memory contents undefined.
//   - Reset mid-transfer discards everything; first edge after release behaves as empty.
//  Accept rules, evaluated on registered state at the edge:
//   - wr_acc = wr_en_i & (~full_o | rd_acc)
//   - rd_acc = rd_en_i & ~empty_o
//  Write on full with a simultaneous read is accepted; level stays DEPTH.
//  Read on empty with a simultaneous write is refused (no bypass); the write lands; level becomes 1.
//  Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally.
//  Level update:
//   - level += wr_acc - rd_acc
//   - Never exceeds DEPTH, never below 0.
//  full_o, empty_o, almost_* and level_o are registered from next-level. They are valid the cycle after the edge that changed level.
//  Read latency: 1 cycle.
//   - rd_acc at edge N: rd_data_o and rd_valid_o=1 at N+1.
//   - rd_valid_o is 0 on cycles with no rd_acc.
//   - rd_data_o holds its last value.
//  Debug:
//   - debug_push_i substitutes DEBUG_WORD for wr_data_i; accept rules unchanged.
//   - debug_pull_i substitutes DEBUG_WORD for RAM output; the pointer still advances.
//  Errors:
//   - wr_en_i & ~wr_acc sets overflow_o and increments drop_cnt_o, saturating at all-ones.
//   - rd_en_i & ~rd_acc sets underflow_o.
//   - Set beats clr_flags_i in the same cycle.
//  Flush:
//   - Pointers and level go to 0 next edge; flags become empty; rd_valid_o=0.
//   - Any wr/rd in the same cycle is ignored and not counted as error.
//   - flush_i beats clr_flags_i priority-free: both act.
// STRUCTURE
//  Package iq_fifo_pkg holds:
//   - IQ_I_LSB / IQ_Q_LSB packing constants.
//   - Default DEBUG_WORD.
//   - The shared gray_conv function, for reuse by the async FIFO.
//  Sub-module iq_fifo_ram:
//   - Simple dual-port, one write and one registered read port, 2*DATA_WIDTH wide.
//   - Infers EBR; no reset on the data array.
//  Top holds pointers, level, flags, counters and debug muxing.
// TESTING  (bench uses ADDR_WIDTH=4, DEPTH=16, af=14, ae=2)
//  1. Write 16 words 0x00010000+k, then a 17th write:
//     - full_o=1 and level_o=16 after the 16th.
//     - 17th dropped: overflow_o=1, drop_cnt_o=1.
//     - Read back returns 0x00010000..0x0001000F in order, 1-cycle latency.
//  2. Full, then simultaneous wr/rd of 0xAAAA5555:
//     - Both accepted, level_o stays 16, no overflow.
//     - 0xAAAA5555 appears as the last word read.
//  3. Empty, then simultaneous wr(0x12345678)/rd:
//     - Read refused, underflow_o=1, level_o=1.
//     - Next read returns 0x12345678 with rd_valid_o=1.
//  4. Write 40 words while reading continuously:
//     - Pointers wrap twice; data order preserved.
//     - almost_full_o high exactly at level>=14; almost_empty_o high at level<=2.
//  5. debug_push_i on 3 writes, then debug_pull_i on the 1st of 3 reads:
//     - All reads return 0xABCDEF01; level_o=0 afterwards.
//  6. Fill to 9, assert flush_i with wr_en_i:
//     - level_o=0 and empty_o=1 next cycle; overflow_o unchanged.
//     - rst_b_i pulsed low mid-write: all outputs at reset values asynchronously.
//  7. Drop 70000 writes with CNT_WIDTH=16:
//     - drop_cnt_o saturates at 0xFFFF.
//     - clr_flags_i clears it to 0.

Source files
------------

// File: rtl/iq_fifo_pkg.sv
// Shared definitions for the I/Q sample FIFOs: component packing, the default
// debug word and the binary-to-gray helper used by the dual-clock variant.
package iq_fifo_pkg;

  // Bit positions of the I and Q components inside a packed {I,Q} word
  // at the default 16-bit component width.
  localparam int unsigned IQ_Q_LSB = 0;
  localparam int unsigned IQ_I_LSB = 16;

  // Word injected or returned by debug push/pull.
  localparam logic [31:0] IQ_DEBUG_WORD_DEFAULT = 32'hABCDEF01;

  // Binary to reflected-gray conversion for pointer crossing.
  function automatic logic [31:0] gray_conv(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/iq_fifo_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register can load an override word instead of the array output so
// debug substitution stays inside the registered path.
// Ports: clk_i/rst_b_i (reset affects the read register only), wr_en_i,
//        wr_addr_i, wr_data_i, rd_en_i, rd_addr_i, rd_ovr_i, rd_ovr_data_i,
//        rd_data_o (registered).
module iq_fifo_ram #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_b_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_ovr_i,
  input  logic [WORD_WIDTH-1:0] rd_ovr_data_i,
  output logic [WORD_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  // Data array: no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: read-before-write when both ports hit the same address
  // (full FIFO with simultaneous push/pop), so the oldest word is returned.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= rd_ovr_i ? rd_ovr_data_i : mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/iq_sync_fifo.sv
// Single-clock {I,Q} sample FIFO with fill level, programmable almost-full /
// almost-empty, sticky overflow/underflow, saturating drop counter,
// synchronous flush and debug-word inject/readback.
// Ports: clk_i, rst_b_i (async active-low), flush_i, wr_en_i, wr_data_i,
//        rd_en_i, rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
//        almost_empty_o, af_thresh_i, ae_thresh_i, level_o, overflow_o,
//        underflow_o, drop_cnt_o, clr_flags_i, debug_push_i, debug_pull_i.
module iq_sync_fifo
  import iq_fifo_pkg::*;
#(
  parameter int unsigned               ADDR_WIDTH = 9,
  parameter int unsigned               DATA_WIDTH = 16,
  parameter logic [2*DATA_WIDTH-1:0]   DEBUG_WORD = (2*DATA_WIDTH)'(IQ_DEBUG_WORD_DEFAULT),
  parameter int unsigned               CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_b_i,
  input  logic                    flush_i,
  input  logic                    wr_en_i,
  input  logic [2*DATA_WIDTH-1:0] wr_data_i,
  input  logic                    rd_en_i,
  output logic [2*DATA_WIDTH-1:0] rd_data_o,
  output logic                    rd_valid_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  input  logic [ADDR_WIDTH:0]     af_thresh_i,
  input  logic [ADDR_WIDTH:0]     ae_thresh_i,
  output logic [ADDR_WIDTH:0]     level_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  output logic [CNT_WIDTH-1:0]    drop_cnt_o,
  input  logic                    clr_flags_i,
  input  logic                    debug_push_i,
  input  logic                    debug_pull_i
);

  localparam int unsigned WORD_W = 2 * DATA_WIDTH;
  localparam int unsigned LVL_W  = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_nxt;
  logic [LVL_W-1:0]      lvl_nxt;
  logic                  wr_acc, rd_acc, wr_drop, rd_refuse;
  logic                  ovf_nxt, udf_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [WORD_W-1:0]     wr_word;

  // Accept/error decode and next-state computation.
  always_comb begin
    rd_acc     = rd_en_i & ~empty_o & ~flush_i;
    wr_acc     = wr_en_i & (~full_o | (rd_en_i & ~empty_o)) & ~flush_i;
    wr_drop    = wr_en_i & ~flush_i & ~wr_acc;
    rd_refuse  = rd_en_i & ~flush_i & ~rd_acc;
    wr_word    = debug_push_i ? DEBUG_WORD : wr_data_i;
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    lvl_nxt    = level_o;

    if (flush_i) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      lvl_nxt    = '0;
    end else begin
      if (wr_acc) wr_ptr_nxt = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_nxt = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   lvl_nxt = level_o + LVL_W'(1);
        2'b01:   lvl_nxt = level_o - LVL_W'(1);
        default: lvl_nxt = level_o;
      endcase
    end

    // A new error event wins over a same-cycle clear.
    ovf_nxt = wr_drop   | (overflow_o  & ~clr_flags_i);
    udf_nxt = rd_refuse | (underflow_o & ~clr_flags_i);
    if (wr_drop) begin
      cnt_nxt = (drop_cnt_o == '1) ? drop_cnt_o : drop_cnt_o + CNT_WIDTH'(1);
    end else if (clr_flags_i) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = drop_cnt_o;
    end
  end

  // Pointer, level, status flag and error registers.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      rd_valid_o     <= 1'b0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
      drop_cnt_o     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_nxt;
      rd_ptr_q       <= rd_ptr_nxt;
      level_o        <= lvl_nxt;
      full_o         <= (lvl_nxt == LVL_W'(DEPTH));
      empty_o        <= (lvl_nxt == '0);
      almost_full_o  <= (lvl_nxt >= af_thresh_i);
      almost_empty_o <= (lvl_nxt <= ae_thresh_i);
      rd_valid_o     <= rd_acc;
      overflow_o     <= ovf_nxt;
      underflow_o    <= udf_nxt;
      drop_cnt_o     <= cnt_nxt;
    end
  end

  iq_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_W)
  ) u_ram (
    .clk_i         (clk_i),
    .rst_b_i       (rst_b_i),
    .wr_en_i       (wr_acc),
    .wr_addr_i     (wr_ptr_q),
    .wr_data_i     (wr_word),
    .rd_en_i       (rd_acc),
    .rd_addr_i     (rd_ptr_q),
    .rd_ovr_i      (debug_pull_i),
    .rd_ovr_data_i (DEBUG_WORD),
    .rd_data_o     (rd_data_o)
  );

endmodule
